// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: FSM state encoding and line constants.
// Combinational definitions only; no latency or backpressure of its own.
package uart_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4,
      ST_BREAK  = 3'd5
   } rx_state_t;

   localparam int   OVERSAMPLE_DEF = 16;
   localparam logic LINE_IDLE      = 1'b1;

endpackage

// File: rtl/uart_rx_fifo.sv
// First-word fall-through byte buffer; rdata shows the head entry while not empty, push-to-visible is 1 clock.
// Backpressure: a push into a full FIFO is dropped unless a pop happens in the same cycle.
module uart_rx_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wptr_q, rptr_q;
   logic [AW:0]      cnt_q;
   logic             do_push, do_pop;

   assign empty   = (cnt_q == '0);
   assign full    = (cnt_q == FULL_CNT);
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);
   // Gate the head so the output is a clean zero whenever nothing is buffered.
   assign rdata   = empty ? '0 : mem_q[rptr_q];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wptr_q <= '0;
         rptr_q <= '0;
         cnt_q  <= '0;
      end else begin
         if (do_push) wptr_q <= wptr_q + 1'b1;
         if (do_pop)  rptr_q <= rptr_q + 1'b1;
         case ({do_push, do_pop})
            2'b10:   cnt_q <= cnt_q + 1'b1;
            2'b01:   cnt_q <= cnt_q - 1'b1;
            default: cnt_q <= cnt_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wptr_q] <= wdata;
   end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receiver: sync + 16x oversampling + bit FSM + FWFT byte FIFO; m_valid rises 1 clock after the stop sample.
// Backpressure via m_ready; a good byte arriving to a full FIFO is dropped with overrun_err. Parity via UART_RX_PARITY_EN.
module uart_rx_ctrl
   import uart_pkg::*;
#(
   parameter int CLK_DIV    = 27,
   parameter int OVERSAMPLE = OVERSAMPLE_DEF,
   parameter int FIFO_DEPTH = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       uart_rx,
   input  logic       en,
   input  logic       err_clr,
   output logic [7:0] m_data,
   output logic       m_valid,
   input  logic       m_ready,
   output logic       rx_busy,
   output logic       framing_err,
   output logic       overrun_err,
   output logic       parity_err
);

   localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int TC_W  = $clog2(OVERSAMPLE);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [TC_W-1:0]  TC_HALF  = TC_W'(OVERSAMPLE / 2 - 1);
   localparam logic [TC_W-1:0]  TC_LAST  = TC_W'(OVERSAMPLE - 1);

   logic             sync1_q, sync2_q, rxs;
   logic [DIV_W-1:0] div_q, div_d;
   logic             tick;
   rx_state_t        state_q, state_d;
   logic [TC_W-1:0]  tcnt_q, tcnt_d;
   logic [2:0]       bidx_q, bidx_d;
   logic [7:0]       shift_q, shift_d;
   logic             fe_q, fe_d, oe_q, oe_d;
   logic             set_fe, set_oe;
   logic             push, pop, fifo_full, fifo_empty, frame_ok;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_q <= LINE_IDLE;
         sync2_q <= LINE_IDLE;
      end else begin
         sync1_q <= uart_rx;
         sync2_q <= sync1_q;
      end
   end
   assign rxs = sync2_q;

   assign tick  = (div_q == DIV_LAST);
   assign div_d = tick ? '0 : div_q + 1'b1;

`ifdef UART_RX_PARITY_EN
   logic par_bad_q, par_bad_d, set_pe, pe_q, pe_d;
   assign frame_ok   = ~par_bad_q;
   assign pe_d       = set_pe | (pe_q & ~err_clr);
   assign parity_err = pe_q;
`else
   assign frame_ok   = 1'b1;
   assign parity_err = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      tcnt_d  = tcnt_q;
      bidx_d  = bidx_q;
      shift_d = shift_q;
      push    = 1'b0;
      set_fe  = 1'b0;
      set_oe  = 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_d = par_bad_q;
      set_pe    = 1'b0;
`endif
      if (!en) begin
         state_d = ST_IDLE;
      end else if (tick) begin
         case (state_q)
            ST_IDLE: begin
               if (!rxs) begin
                  state_d = ST_START;
                  tcnt_d  = '0;
               end
            end
            ST_START: begin
               if (tcnt_q == TC_HALF) begin
                  tcnt_d  = '0;
                  bidx_d  = '0;
                  state_d = rxs ? ST_IDLE : ST_DATA;
               end else begin
                  tcnt_d = tcnt_q + 1'b1;
               end
            end
            ST_DATA: begin
               if (tcnt_q == TC_LAST) begin
                  shift_d[bidx_q] = rxs;
                  tcnt_d = '0;
                  bidx_d = bidx_q + 3'd1;
                  if (bidx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                     state_d = ST_PARITY;
`else
                     state_d = ST_STOP;
`endif
                  end
               end else begin
                  tcnt_d = tcnt_q + 1'b1;
               end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
               if (tcnt_q == TC_LAST) begin
                  tcnt_d    = '0;
                  state_d   = ST_STOP;
                  par_bad_d = ^{shift_q, rxs};
                  set_pe    = par_bad_d;
               end else begin
                  tcnt_d = tcnt_q + 1'b1;
               end
            end
`endif
            ST_STOP: begin
               if (tcnt_q == TC_LAST) begin
                  tcnt_d = '0;
                  if (rxs) begin
                     state_d = ST_IDLE;
                     if (frame_ok) begin
                        if (fifo_full && !pop) set_oe = 1'b1;
                        else                   push   = 1'b1;
                     end
                  end else begin
                     set_fe  = 1'b1;
                     state_d = ST_BREAK;
                  end
               end else begin
                  tcnt_d = tcnt_q + 1'b1;
               end
            end
            // Held-low line after a bad stop must go high before a new start is armed.
            ST_BREAK: begin
               if (rxs) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   assign fe_d = set_fe | (fe_q & ~err_clr);
   assign oe_d = set_oe | (oe_q & ~err_clr);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         div_q   <= '0;
         state_q <= ST_IDLE;
         tcnt_q  <= '0;
         bidx_q  <= '0;
         shift_q <= '0;
         fe_q    <= 1'b0;
         oe_q    <= 1'b0;
      end else begin
         div_q   <= div_d;
         state_q <= state_d;
         tcnt_q  <= tcnt_d;
         bidx_q  <= bidx_d;
         shift_q <= shift_d;
         fe_q    <= fe_d;
         oe_q    <= oe_d;
      end
   end

`ifdef UART_RX_PARITY_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         par_bad_q <= 1'b0;
         pe_q      <= 1'b0;
      end else begin
         par_bad_q <= par_bad_d;
         pe_q      <= pe_d;
      end
   end
`endif

   assign pop         = m_valid & m_ready;
   assign m_valid     = ~fifo_empty;
   assign rx_busy     = (state_q != ST_IDLE);
   assign framing_err = fe_q;
   assign overrun_err = oe_q;

   uart_rx_fifo #(
      .WIDTH (8),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (pop),
      .wdata (shift_q),
      .rdata (m_data),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

endmodule

// File: doc/uart_rx_ctrl.md
# uart_rx_ctrl

Receive-side controller for the UART path. It runs from the system clock and does four jobs: synchronizes the serial line, generates 16x oversample timing, sequences start/data/stop bit sampling at bit centres, and buffers received bytes in a small FIFO with a valid/ready output. Line errors are reported as sticky flags. It sits between the pad and any byte consumer (command parser, register bridge), and replaces the externally supplied baud strobe with internally derived timing.

## Interface
- `CLK_DIV`, default 27: system clocks per oversample tick; must be ≥ 2.
- `OVERSAMPLE`, default 16: ticks per bit; must be even and ≥ 4.
- `FIFO_DEPTH`, default 4: byte buffer entries; must be a power of two and ≥ 2.

- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous, active-high reset.
- `uart_rx`  in  1  asynchronous serial input; idle is high.
- `en`  in  1  receive enable.
- `err_clr`  in  1  single-cycle clear of all sticky errors.
- `m_data`  out  8  head-of-FIFO byte.
- `m_valid`  out  1  FIFO not empty.
- `m_ready`  in  1  consumer accepts the head byte.
- `rx_busy`  out  1  FSM not in IDLE.
- `framing_err`  out  1  sticky: stop bit sampled low.
- `overrun_err`  out  1  sticky: good byte arrived while FIFO was full.
- `parity_err`  out  1  sticky; driven to 0 unless the parity feature is compiled in.

## Operation
- **Synchronizer:** 2-flop on `uart_rx`; both flops reset to 1. All sampling uses the synchronized value `rxs`.
- **Tick generator:** a free-running divider asserts `tick` for 1 clock every `CLK_DIV` clocks. It resets to 0.
- **FSM states:** IDLE, START, DATA, (PARITY), STOP, BREAK. `tcnt` counts ticks; `bidx` is 3 bits.
  - **IDLE:** on `tick` with `rxs`=0 and `en`=1, go to START with `tcnt`=0.
  - **START:** on the tick where `tcnt`=OVERSAMPLE/2−1, check `rxs`.
    - `rxs`=0: go to DATA with `tcnt`=0 and `bidx`=0.
    - `rxs`=1: false start; go to IDLE with no flag.
  - **DATA:** on the tick where `tcnt`=OVERSAMPLE−1, set `shift[bidx]`←`rxs` (LSB first) and `tcnt`←0.
    - After `bidx`=7, go to PARITY if compiled in, else STOP.
  - **STOP:** on the tick where `tcnt`=OVERSAMPLE−1:
    - `rxs`=1 and FIFO not full (or popped in the same cycle): push `shift`, go to IDLE.
    - `rxs`=1 and FIFO full with no pop: set `overrun_err`, drop the byte, go to IDLE.
    - `rxs`=0: set `framing_err`, drop the byte, go to BREAK.
  - **BREAK:** stay until `rxs`=1 on a tick, then go to IDLE. This prevents a held-low line from retriggering START.
- **Enable:** `en`=0 forces the FSM to IDLE on the next clock and discards any partial byte. FIFO contents and flags are retained.
- **FIFO:** first-word fall-through.
  - Pop when `m_valid`&`m_ready`.
  - Push and pop in the same cycle are both performed, including when full.
  - `m_valid`=0 ignores `m_ready`.
- **Sticky flags:** if set and `err_clr` occur in the same cycle, set wins.

## Timing
- **Reset values:**
  - outputs: `m_data`=0, `m_valid`=0, `rx_busy`=0, all error flags 0;
  - internal: FSM in IDLE, FIFO empty, divider 0.
- **Bit period:** CLK_DIV×OVERSAMPLE clocks. Data samples fall at nominal bit centres ±1 tick.
- **Latency:** `m_valid` rises the clock after the stop-bit sample edge, and `m_data` is valid in that same cycle.
- **Pop timing:** after a pop, the next entry appears on `m_data` in the following cycle.
- **Start detection:** at most 1 tick plus 2 clocks after the line edge.
- **Mid-frame reset:** all state and FIFO contents are cleared immediately, and the in-flight byte is lost.

## Configuration
- `UART_RX_PARITY_EN` defined:
  - PARITY state is inserted between DATA and STOP and samples 1 bit at bit centre.
  - If parity is not even (XOR of 8 data bits and parity bit ≠ 0), set `parity_err`, drop the byte, and continue to STOP. STOP still checks framing.
- Undefined: no PARITY state, the frame is 10 bits, and `parity_err` is tied to 0.

## Structure
- **`uart_pkg`:**
  - FSM state encoding;
  - default `OVERSAMPLE`;
  - idle line level constant (1).
- **Sub-module `uart_rx_fifo`:** parameterised width/depth, FWFT, with signals `push`, `pop`, `full`, `empty`, `wdata` and `rdata`. The FSM, divider and synchronizer stay in `uart_rx_ctrl`.

## Test plan
Bench settings: `CLK_DIV`=4, `OVERSAMPLE`=16, giving 64 clocks per bit.

- **Single byte:** send 0xA5 with a good stop bit and `m_ready`=1 → `m_valid` pulses 1 cycle with `m_data`=0xA5 and no error flags.
- **Glitch start:** drive a 20-clock low glitch → FSM returns to IDLE, no push, no flags.
- **Framing error:** send 0x3C with stop=0 and the line held low 200 clocks → `framing_err`=1, FIFO stays empty, and no new START occurs until the line goes high. A subsequent 0x11 is received correctly.
- **Overrun:** with `m_ready`=0, send 0x01..0x05 → FIFO holds 0x01..0x04 and `overrun_err`=1. Then `err_clr` clears the flag, and draining yields 0x01..0x04 in order.
- **Mid-frame interruptions:**
  - Deasserting `en` after bit 3 of 0xFF → no push and `rx_busy`=0 next cycle.
  - Asserting `rst` mid-frame → all outputs return to reset values.
- **Parity (with `UART_RX_PARITY_EN`):** send 0x07 with parity bit 0 → `parity_err`=1 and no push. Then send 0x07 with parity 1 → `m_data`=0x07 is pushed.
